cr_dct_8x8: RTL and testbench

- 2-D 8x8 forward DCT for the Cr (chroma-red) channel of the JPEG encoder.
- Sits between colour conversion and Cr quantisation.
- Accepts 64 unsigned 8-bit samples serially in raster order, level-shifts by 128, and computes Z = T·X·Tᵀ.
- Presents all 64 coefficients in parallel as 11-bit signed values, with a one-cycle output_enable strobe.

---
 rtl/cr_dct_8x8.sv | 171 +++++++++++++++++
 tb/tb_cr_dct_8x8.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_dct_8x8.sv
// cr_dct_8x8: 8x8 forward DCT (Z = T*X*T') for the JPEG Cr channel
// Samples arrive serially in raster order, are level-shifted by 128, and the
// 64 coefficients of each block are presented in parallel.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   enable         qualifies data_in; one sample accepted per edge while high
//   data_in        unsigned 8-bit Cr sample, index i = 8*row + col
//   Z11..Z88_final signed coefficients, Zuv: u vertical, v horizontal frequency
//   output_enable  one-cycle strobe when a new coefficient block is presented
// Build option: define CR_DCT_SAT_EN to saturate coefficients to the output
// range; otherwise the rounded value wraps to its low OUT_BITS bits.
module cr_dct_8x8 #(
   parameter int COEF_BITS = 13,
   parameter int OUT_BITS  = 11
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [7:0]                 data_in,
   output logic signed [OUT_BITS-1:0] Z11_final, Z12_final, Z13_final, Z14_final, Z15_final, Z16_final, Z17_final, Z18_final,
                                      Z21_final, Z22_final, Z23_final, Z24_final, Z25_final, Z26_final, Z27_final, Z28_final,
                                      Z31_final, Z32_final, Z33_final, Z34_final, Z35_final, Z36_final, Z37_final, Z38_final,
                                      Z41_final, Z42_final, Z43_final, Z44_final, Z45_final, Z46_final, Z47_final, Z48_final,
                                      Z51_final, Z52_final, Z53_final, Z54_final, Z55_final, Z56_final, Z57_final, Z58_final,
                                      Z61_final, Z62_final, Z63_final, Z64_final, Z65_final, Z66_final, Z67_final, Z68_final,
                                      Z71_final, Z72_final, Z73_final, Z74_final, Z75_final, Z76_final, Z77_final, Z78_final,
                                      Z81_final, Z82_final, Z83_final, Z84_final, Z85_final, Z86_final, Z87_final, Z88_final,
   output logic                       output_enable
);
   localparam int RW = 26;
   localparam int CW = COEF_BITS + RW + 3;
`ifdef CR_DCT_SAT_EN
   localparam logic signed [CW-1:0] ZMAX = CW'((1 << (OUT_BITS - 1)) - 1);
   localparam logic signed [CW-1:0] ZMIN = -ZMAX - 1;
`endif

   // T[u][x] = round(4096*c(u)*cos((2x+1)u*pi/16)); the angle is folded onto
   // 0..pi so only nine cosine magnitudes are stored.
   function automatic logic signed [COEF_BITS-1:0] coef(input logic [2:0] u, input logic [2:0] x);
      logic [4:0]  p;
      logic [4:0]  m;
      logic [3:0]  k;
      logic [11:0] mag;
      p = 5'({x, 1'b1} * {1'b0, u});
      m = (p[4] && p[3:0] != 4'd0) ? 5'd0 - p : p;
      k = (m > 5'd8) ? 4'(5'd16 - m) : m[3:0];
      case (k)
         4'd0:    mag = 12'd2048;
         4'd1:    mag = 12'd2009;
         4'd2:    mag = 12'd1892;
         4'd3:    mag = 12'd1703;
         4'd4:    mag = 12'd1448;
         4'd5:    mag = 12'd1138;
         4'd6:    mag = 12'd784;
         4'd7:    mag = 12'd400;
         default: mag = 12'd0;
      endcase
      if (u == 3'd0) mag = 12'd1448;
      coef = (u != 3'd0 && m > 5'd8) ? -$signed(COEF_BITS'(mag)) : $signed(COEF_BITS'(mag));
   endfunction

   // Round half up from the 2^24 scale, then fit to the output width.
   function automatic logic signed [OUT_BITS-1:0] reduce(input logic signed [CW-1:0] a);
      logic signed [CW-1:0] r;
      r = (a + $signed(CW'(1 << 23))) >>> 24;
`ifdef CR_DCT_SAT_EN
      reduce = r > ZMAX ? ZMAX[OUT_BITS-1:0] : r < ZMIN ? ZMIN[OUT_BITS-1:0] : r[OUT_BITS-1:0];
`else
      reduce = r[OUT_BITS-1:0];
`endif
   endfunction

   logic        [5:0]          cnt;
   logic signed [8:0]          s;
   logic signed [RW-1:0]       acc [8];
   logic signed [RW-1:0]       rbuf [8];
   logic signed [RW-1:0]       rsum [8];
   logic signed [CW-1:0]       zacc [64];
   logic signed [OUT_BITS-1:0] res [64];
   logic signed [OUT_BITS-1:0] zf [64];
   logic                       row_done;
   logic                       cp_busy;
   logic        [2:0]          cp_u;
   logic        [2:0]          cp_x;
   logic                       fin;
   logic        [2:0]          dly;

   assign s        = $signed({1'b0, data_in} - 9'd128);
   assign row_done = enable && &cnt[2:0];

   // Row pass: eight running dot products of the current row against T rows.
   always_comb begin
      for (int v = 0; v < 8; v++)
         rsum[v] = (cnt[2:0] == 3'd0 ? RW'(0) : acc[v]) + RW'(s * coef(3'(v), cnt[2:0]));
   end

   // A finished row moves to rbuf so the next row can accumulate while the
   // column pass consumes it.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt  <= '0;
         acc  <= '{default: '0};
         rbuf <= '{default: '0};
      end else if (enable) begin
         cnt <= cnt + 6'd1;
         acc <= rsum;
         if (&cnt[2:0]) rbuf <= rsum;
      end

   // Column pass: one frequency u per cycle over eight cycles per row, which
   // always finishes before the next row can complete.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cp_busy <= 1'b0;
         cp_u    <= '0;
         cp_x    <= '0;
         fin     <= 1'b0;
      end else begin
         fin <= cp_busy && &cp_u && &cp_x;
         if (row_done) begin
            cp_busy <= 1'b1;
            cp_u    <= '0;
            cp_x    <= cnt[5:3];
         end else if (cp_busy) begin
            cp_u    <= cp_u + 3'd1;
            cp_busy <= ~&cp_u;
         end
      end

   // Row 0 overwrites instead of accumulating, so no clear cycle is needed
   // between blocks.
   always_ff @(posedge clk or negedge rst)
      if (!rst) zacc <= '{default: '0};
      else if (cp_busy)
         for (int v = 0; v < 8; v++)
            zacc[{cp_u, 3'(v)}] <= (cp_x == 3'd0 ? CW'(0) : zacc[{cp_u, 3'(v)}]) + CW'(coef(cp_u, cp_x) * rbuf[v]);

   // Results are snapshotted one edge after the last column update (before
   // the next block can overwrite zacc) and presented three edges later.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         res           <= '{default: '0};
         zf            <= '{default: '0};
         dly           <= '0;
         output_enable <= 1'b0;
      end else begin
         dly           <= {dly[1:0], fin};
         output_enable <= dly[2];
         if (fin)
            for (int i = 0; i < 64; i++) res[i] <= reduce(zacc[i]);
         if (dly[2]) zf <= res;
      end

   assign Z11_final = zf[0];  assign Z12_final = zf[1];  assign Z13_final = zf[2];  assign Z14_final = zf[3];
   assign Z15_final = zf[4];  assign Z16_final = zf[5];  assign Z17_final = zf[6];  assign Z18_final = zf[7];
   assign Z21_final = zf[8];  assign Z22_final = zf[9];  assign Z23_final = zf[10]; assign Z24_final = zf[11];
   assign Z25_final = zf[12]; assign Z26_final = zf[13]; assign Z27_final = zf[14]; assign Z28_final = zf[15];
   assign Z31_final = zf[16]; assign Z32_final = zf[17]; assign Z33_final = zf[18]; assign Z34_final = zf[19];
   assign Z35_final = zf[20]; assign Z36_final = zf[21]; assign Z37_final = zf[22]; assign Z38_final = zf[23];
   assign Z41_final = zf[24]; assign Z42_final = zf[25]; assign Z43_final = zf[26]; assign Z44_final = zf[27];
   assign Z45_final = zf[28]; assign Z46_final = zf[29]; assign Z47_final = zf[30]; assign Z48_final = zf[31];
   assign Z51_final = zf[32]; assign Z52_final = zf[33]; assign Z53_final = zf[34]; assign Z54_final = zf[35];
   assign Z55_final = zf[36]; assign Z56_final = zf[37]; assign Z57_final = zf[38]; assign Z58_final = zf[39];
   assign Z61_final = zf[40]; assign Z62_final = zf[41]; assign Z63_final = zf[42]; assign Z64_final = zf[43];
   assign Z65_final = zf[44]; assign Z66_final = zf[45]; assign Z67_final = zf[46]; assign Z68_final = zf[47];
   assign Z71_final = zf[48]; assign Z72_final = zf[49]; assign Z73_final = zf[50]; assign Z74_final = zf[51];
   assign Z75_final = zf[52]; assign Z76_final = zf[53]; assign Z77_final = zf[54]; assign Z78_final = zf[55];
   assign Z81_final = zf[56]; assign Z82_final = zf[57]; assign Z83_final = zf[58]; assign Z84_final = zf[59];
   assign Z85_final = zf[60]; assign Z86_final = zf[61]; assign Z87_final = zf[62]; assign Z88_final = zf[63];
endmodule

// File: tb/tb_cr_dct_8x8.sv
// tb_cr_dct_8x8: scoreboard bench for cr_dct_8x8 against a floating-point DCT model
module tb_cr_dct_8x8;
   localparam real PI  = 3.14159265358979323846;
   localparam real CS0 = 0.35355339059327373;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              enable = 1'b0;
   logic [7:0]        data_in = 8'd0;
   logic signed [10:0] z [64];
   logic              output_enable;
   int                n_chk = 0;
   int                n_fail = 0;
   int                exp_q [$];

   always #5 clk = ~clk;

   cr_dct_8x8 dut (
      .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
      .Z11_final(z[0]),  .Z12_final(z[1]),  .Z13_final(z[2]),  .Z14_final(z[3]),  .Z15_final(z[4]),  .Z16_final(z[5]),  .Z17_final(z[6]),  .Z18_final(z[7]),
      .Z21_final(z[8]),  .Z22_final(z[9]),  .Z23_final(z[10]), .Z24_final(z[11]), .Z25_final(z[12]), .Z26_final(z[13]), .Z27_final(z[14]), .Z28_final(z[15]),
      .Z31_final(z[16]), .Z32_final(z[17]), .Z33_final(z[18]), .Z34_final(z[19]), .Z35_final(z[20]), .Z36_final(z[21]), .Z37_final(z[22]), .Z38_final(z[23]),
      .Z41_final(z[24]), .Z42_final(z[25]), .Z43_final(z[26]), .Z44_final(z[27]), .Z45_final(z[28]), .Z46_final(z[29]), .Z47_final(z[30]), .Z48_final(z[31]),
      .Z51_final(z[32]), .Z52_final(z[33]), .Z53_final(z[34]), .Z54_final(z[35]), .Z55_final(z[36]), .Z56_final(z[37]), .Z57_final(z[38]), .Z58_final(z[39]),
      .Z61_final(z[40]), .Z62_final(z[41]), .Z63_final(z[42]), .Z64_final(z[43]), .Z65_final(z[44]), .Z66_final(z[45]), .Z67_final(z[46]), .Z68_final(z[47]),
      .Z71_final(z[48]), .Z72_final(z[49]), .Z73_final(z[50]), .Z74_final(z[51]), .Z75_final(z[52]), .Z76_final(z[53]), .Z77_final(z[54]), .Z78_final(z[55]),
      .Z81_final(z[56]), .Z82_final(z[57]), .Z83_final(z[58]), .Z84_final(z[59]), .Z85_final(z[60]), .Z86_final(z[61]), .Z87_final(z[62]), .Z88_final(z[63]),
      .output_enable(output_enable)
   );

   // 0: const 128, 1: const 255, 2: const 0, 3: ramp i+10, 4: checkerboard 0/255
   function automatic int pix(input int mode, input int i);
      case (mode)
         0: return 128;
         1: return 255;
         2: return 0;
         3: return i + 10;
         default: return (((i >> 3) + i) & 1) != 0 ? 255 : 0;
      endcase
   endfunction

   task automatic push_model(input int mode);
      for (int u = 0; u < 8; u++)
         for (int v = 0; v < 8; v++) begin
            real sum;
            int  r;
            sum = 0.0;
            for (int x = 0; x < 8; x++)
               for (int y = 0; y < 8; y++)
                  sum = sum + (pix(mode, 8 * x + y) - 128) * $cos((2 * x + 1) * u * PI / 16.0) * $cos((2 * y + 1) * v * PI / 16.0);
            sum = sum * (u == 0 ? CS0 : 0.5) * (v == 0 ? CS0 : 0.5);
            r = $rtoi($floor(sum + 0.5));
`ifdef CR_DCT_SAT_EN
            r = r > 1023 ? 1023 : r < -1024 ? -1024 : r;
`else
            r = ((r + 1024) & 2047) - 1024;
`endif
            exp_q.push_back(r);
         end
   endtask

   // Drives n samples; returns #1 after the edge that captured the last one.
   task automatic send_block(input int mode, input bit gaps, input int n, input bit push);
      if (push) push_model(mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         enable  = 1'b1;
         data_in = 8'(pix(mode, i));
         if (gaps && i != n - 1) begin
            @(negedge clk);
            enable  = 1'b0;
            data_in = 8'($urandom);
         end
      end
      @(posedge clk);
      #1;
      enable = 1'b0;
   endtask

   task automatic wait_strobe(input int limit, output int lat);
      lat = -1;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (output_enable === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst    = 1'b0;
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (output_enable !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", output_enable); end
      for (int k = 0; k < 64; k++) begin
         n_chk++;
         if (z[k] !== '0) begin n_fail++; $display("FAIL reset_z Z%0d%0d got %0d want 0", k / 8 + 1, k % 8 + 1, z[k]); end
      end
      @(negedge clk);
      rst     = 1'b1;
      data_in = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (output_enable !== 1'b0) begin n_fail++; $display("FAIL release_oe got %b want 0", output_enable); end
      for (int k = 0; k < 64; k++) begin
         n_chk++;
         if (z[k] !== '0) begin n_fail++; $display("FAIL release_z Z%0d%0d got %0d want 0", k / 8 + 1, k % 8 + 1, z[k]); end
      end
   endtask

   task automatic test_patterns;
      int lat;
      int modes [4] = '{0, 1, 2, 4};
      int dc [4]    = '{0, 1016, -1024, -4};
      for (int m = 0; m < 4; m++) begin
         send_block(modes[m], 1'b0, 64, 1'b1);
         wait_strobe(40, lat);
         n_chk++;
         if (lat != 12) begin n_fail++; $display("FAIL pat%0d_latency got %0d want 12", modes[m], lat); end
         n_chk++;
         if (int'(z[0]) != dc[m]) begin n_fail++; $display("FAIL pat%0d_dc got %0d want %0d", modes[m], z[0], dc[m]); end
         for (int k = 0; k < 64; k++) begin
            int e;
            int d;
            e = exp_q.pop_front();
            d = int'(z[k]) - e;
            n_chk++;
            if (d > 1 || d < -1) begin n_fail++; $display("FAIL pat%0d Z%0d%0d got %0d want %0d", modes[m], k / 8 + 1, k % 8 + 1, z[k], e); end
         end
         @(posedge clk);
         #1;
         n_chk++;
         if (output_enable !== 1'b0) begin n_fail++; $display("FAIL pat%0d_pulse_width got %b want 0", modes[m], output_enable); end
      end
   endtask

   task automatic test_ramp(input bit gaps);
      int lat;
      send_block(3, gaps, 64, 1'b1);
      wait_strobe(40, lat);
      n_chk++;
      if (lat != 12) begin n_fail++; $display("FAIL ramp%0d_latency got %0d want 12", gaps, lat); end
      n_chk++;
      if (int'(z[0]) != -692) begin n_fail++; $display("FAIL ramp%0d_Z11 got %0d want -692", gaps, z[0]); end
      n_chk++;
      if (int'(z[1]) != -18) begin n_fail++; $display("FAIL ramp%0d_Z12 got %0d want -18", gaps, z[1]); end
      n_chk++;
      if (int'(z[8]) != -146) begin n_fail++; $display("FAIL ramp%0d_Z21 got %0d want -146", gaps, z[8]); end
      for (int k = 0; k < 64; k++) begin
         int e;
         int d;
         e = exp_q.pop_front();
         d = int'(z[k]) - e;
         n_chk++;
         if (d > 1 || d < -1) begin n_fail++; $display("FAIL ramp%0d Z%0d%0d got %0d want %0d", gaps, k / 8 + 1, k % 8 + 1, z[k], e); end
      end
      repeat (6) @(posedge clk);
      #1;
      n_chk++;
      if (int'(z[0]) != -692) begin n_fail++; $display("FAIL ramp%0d_hold got %0d want -692", gaps, z[0]); end
   endtask

   task automatic test_back_to_back;
      int  lat;
      time t [2];
      t[0] = 0;
      t[1] = 0;
      fork
         begin
            send_block(3, 1'b0, 64, 1'b1);
            send_block(0, 1'b0, 64, 1'b1);
         end
         for (int b = 0; b < 2; b++) begin
            wait_strobe(b == 0 ? 200 : 100, lat);
            t[b] = $time;
            n_chk++;
            if (lat < 0) begin n_fail++; $display("FAIL b2b_strobe%0d got none want pulse", b); end
            n_chk++;
            if (int'(z[0]) != (b == 0 ? -692 : 0)) begin n_fail++; $display("FAIL b2b%0d_Z11 got %0d want %0d", b, z[0], b == 0 ? -692 : 0); end
            for (int k = 0; k < 64; k++) begin
               int e;
               int d;
               e = exp_q.pop_front();
               d = int'(z[k]) - e;
               n_chk++;
               if (d > 1 || d < -1) begin n_fail++; $display("FAIL b2b%0d Z%0d%0d got %0d want %0d", b, k / 8 + 1, k % 8 + 1, z[k], e); end
            end
         end
      join
      n_chk++;
      if (t[1] - t[0] != 640) begin n_fail++; $display("FAIL b2b_spacing got %0d want 640", t[1] - t[0]); end
   endtask

   task automatic test_reset_mid;
      int lat;
      send_block(1, 1'b0, 64, 1'b0);
      wait_strobe(40, lat);
      n_chk++;
      if (int'(z[0]) != 1016) begin n_fail++; $display("FAIL rstmid_pre_Z11 got %0d want 1016", z[0]); end
      send_block(2, 1'b0, 64, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      wait_strobe(30, lat);
      n_chk++;
      if (lat != -1) begin n_fail++; $display("FAIL rstmid_strobe got %0d want none", lat); end
      for (int k = 0; k < 64; k++) begin
         n_chk++;
         if (z[k] !== '0) begin n_fail++; $display("FAIL rstmid_z Z%0d%0d got %0d want 0", k / 8 + 1, k % 8 + 1, z[k]); end
      end
      send_block(1, 1'b0, 20, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      send_block(2, 1'b0, 64, 1'b1);
      wait_strobe(40, lat);
      n_chk++;
      if (lat != 12) begin n_fail++; $display("FAIL rstmid_after_latency got %0d want 12", lat); end
      n_chk++;
      if (int'(z[0]) != -1024) begin n_fail++; $display("FAIL rstmid_after_Z11 got %0d want -1024", z[0]); end
      for (int k = 0; k < 64; k++) begin
         int e;
         int d;
         e = exp_q.pop_front();
         d = int'(z[k]) - e;
         n_chk++;
         if (d > 1 || d < -1) begin n_fail++; $display("FAIL rstmid_after Z%0d%0d got %0d want %0d", k / 8 + 1, k % 8 + 1, z[k], e); end
      end
   endtask

   initial begin
      test_reset;
      test_patterns;
      test_ramp(1'b0);
      test_ramp(1'b1);
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
